// File: rtl/sound_ctrl.sv
// Tone sequencer: queues 8-bit note commands in a 4-deep FIFO and plays each
// as a timed tone (or rest), followed by a short silent gap.
module sound_ctrl #(
  parameter int TICK_CYCLES = 500000,
  parameter int GAP_CYCLES  = 50000
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] cmd,
  input  logic       stop,
  output logic [2:0] tone_sel,
  output logic       snd_off,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int PW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam int GW = ($clog2(GAP_CYCLES) > 17) ? $clog2(GAP_CYCLES) : 17;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      fifo_mem [4];
  logic [1:0]      wptr_q, rptr_q;
  logic [2:0]      cnt_q;
  logic [7:0]      cmd_q;
  logic [2:0]      tone_q;
  logic            ovf_q;
  logic [PW-1:0]   presc_q;
  logic [4:0]      tick_q;
  logic [GW-1:0]   gap_q;
  logic            pop, push, drop, wrap;

  always_comb begin
    wrap    = (presc_q == PRESC_LAST);
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cnt_q != 3'd0) begin
          pop     = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_PLAY;
      S_PLAY: begin
        // D=0 means "play until something else is queued"
        if (cmd_q[7:3] != 5'd0) begin
          if (wrap && ((tick_q + 5'd1) == cmd_q[7:3])) state_d = S_GAP;
        end else if (cnt_q != 3'd0) begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (stop) begin
      state_d = S_IDLE;
      pop     = 1'b0;
    end
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write then
    push = wr && !stop && ((cnt_q != 3'd4) || pop);
    drop = wr && !stop && (cnt_q == 3'd4) && !pop;
  end

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      wptr_q <= 2'd0;
      rptr_q <= 2'd0;
      cnt_q  <= 3'd0;
      ovf_q  <= 1'b0;
      tone_q <= 3'd0;
    end else if (stop) begin
      wptr_q <= 2'd0;
      rptr_q <= 2'd0;
      cnt_q  <= 3'd0;
      ovf_q  <= 1'b0;
      tone_q <= 3'd0;
    end else begin
      if (push) wptr_q <= wptr_q + 2'd1;
      if (pop)  rptr_q <= rptr_q + 2'd1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 3'd1;
        2'b01:   cnt_q <= cnt_q - 3'd1;
        default: cnt_q <= cnt_q;
      endcase
      if (drop) ovf_q <= 1'b1;
      if (state_q == S_LOAD) tone_q <= cmd_q[2:0];
    end
  end

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      tick_q  <= 5'd0;
      gap_q   <= '0;
    end else begin
      if (state_q == S_LOAD) begin
        presc_q <= '0;
        tick_q  <= 5'd0;
      end else if (state_q == S_PLAY) begin
        if (wrap) begin
          presc_q <= '0;
          tick_q  <= tick_q + 5'd1;
        end else begin
          presc_q <= presc_q + 1'b1;
        end
      end
      if ((state_d == S_GAP) && (state_q != S_GAP)) gap_q <= '0;
      else if (state_q == S_GAP)                    gap_q <= gap_q + 1'b1;
    end
  end

  // FIFO storage and the latched command carry data only, so no reset
  always_ff @(posedge clk_50M) begin
    if (push) fifo_mem[wptr_q] <= cmd;
    if (pop)  cmd_q <= fifo_mem[rptr_q];
  end

  assign tone_sel  = tone_q;
  assign snd_off   = !((state_q == S_PLAY) && (tone_q != 3'd0));
  assign busy      = (state_q != S_IDLE) || (cnt_q != 3'd0);
  assign fifo_full = (cnt_q == 3'd4);
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_sound_ctrl.sv
// Directed bench for sound_ctrl with TICK_CYCLES=10, GAP_CYCLES=3.
module tb_sound_ctrl;

  logic       clk_50M = 1'b0;
  logic       reset;
  logic       wr;
  logic [7:0] cmd;
  logic       stop;
  logic [2:0] tone_sel;
  logic       snd_off;
  logic       busy;
  logic       fifo_full;
  logic       overflow;

  int n_chk = 0;
  int n_err = 0;

  sound_ctrl #(.TICK_CYCLES(10), .GAP_CYCLES(3)) dut (
    .clk_50M  (clk_50M),
    .reset    (reset),
    .wr       (wr),
    .cmd      (cmd),
    .stop     (stop),
    .tone_sel (tone_sel),
    .snd_off  (snd_off),
    .busy     (busy),
    .fifo_full(fifo_full),
    .overflow (overflow)
  );

  always #5 clk_50M = ~clk_50M;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Called at a falling edge; the write is captured on the next rising edge.
  task automatic wr_cmd(input logic [7:0] c);
    wr  = 1'b1;
    cmd = c;
    @(negedge clk_50M);
    wr  = 1'b0;
  endtask

  task automatic wait_play(output int lat);
    lat = 0;
    while (snd_off && lat < 400) begin
      @(negedge clk_50M);
      lat++;
    end
  endtask

  task automatic play_len(input logic [2:0] et, output int n, output int bad);
    n = 0;
    bad = 0;
    while (!snd_off && n < 400) begin
      if (tone_sel != et) bad++;
      @(negedge clk_50M);
      n++;
    end
  endtask

  task automatic off_len(output int n);
    n = 0;
    while (snd_off && busy && n < 400) begin
      @(negedge clk_50M);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, n, bad, z, notes;
    logic prev_off;
    logic [2:0] seq [8];

    reset = 1'b1;
    wr    = 1'b0;
    cmd   = 8'h00;
    stop  = 1'b0;
    #12;
    check("rst_snd_off", snd_off, 1);
    check("rst_busy", busy, 0);
    check("rst_tone_sel", tone_sel, 0);
    check("rst_full", fifo_full, 0);
    check("rst_overflow", overflow, 0);
    @(negedge clk_50M);
    reset = 1'b0;
    @(negedge clk_50M);
    check("post_rst_busy", busy, 0);

    // Single note: tone 3 for 2 ticks
    wr_cmd(8'h13);
    wait_play(lat);
    check("t1_latency", lat, 2);
    play_len(3'd3, n, bad);
    check("t1_play_len", n, 20);
    check("t1_tone_bad", bad, 0);
    check("t1_gap_tone", tone_sel, 3);
    off_len(n);
    check("t1_gap_len", n, 3);
    check("t1_busy_end", busy, 0);

    // Rest: stays silent, busy through IDLE/LOAD/PLAY/GAP
    wr_cmd(8'h08);
    n = 0;
    z = 0;
    while (busy && n < 400) begin
      if (!snd_off) z++;
      @(negedge clk_50M);
      n++;
    end
    check("t2_busy_len", n, 15);
    check("t2_sound_cycles", z, 0);
    check("t2_tone_sel", tone_sel, 0);

    // Overflow: 6 writes during a note, only 4 fit
    wr_cmd(8'h11);
    wait_play(lat);
    check("t3_latency", lat, 2);
    wr_cmd(8'h0A);
    wr_cmd(8'h0B);
    wr_cmd(8'h0C);
    wr_cmd(8'h0D);
    wr_cmd(8'h0E);
    wr_cmd(8'h0F);
    check("t3_full", fifo_full, 1);
    check("t3_overflow", overflow, 1);
    seq[0] = tone_sel;
    notes = 1;
    prev_off = snd_off;
    for (int c = 0; c < 1000 && busy; c++) begin
      @(negedge clk_50M);
      if (!snd_off && prev_off && notes < 8) begin
        seq[notes] = tone_sel;
        notes++;
      end
      prev_off = snd_off;
    end
    check("t3_busy_end", busy, 0);
    check("t3_notes", notes, 5);
    for (int i = 0; i < 5; i++) check($sformatf("t3_seq%0d", i), seq[i], i + 1);

    // Continuous note ended by a new queued command
    wr_cmd(8'h05);
    wait_play(lat);
    repeat (100) @(negedge clk_50M);
    check("t4_still_on", snd_off, 0);
    check("t4_tone5", tone_sel, 5);
    wr_cmd(8'h0A);
    play_len(3'd5, n, bad);
    check("t4_tail", n, 1);
    check("t4_gap_tone", tone_sel, 5);
    off_len(n);
    check("t4_gap_to_play", n, 5);
    play_len(3'd2, n, bad);
    check("t4_tone2_len", n, 10);
    check("t4_tone2_bad", bad, 0);
    off_len(n);
    check("t4_end_gap", n, 3);

    // Stop with a same-cycle write while 3 entries are queued
    wr_cmd(8'hF9);
    wait_play(lat);
    check("t5_latency", lat, 2);
    wr_cmd(8'h0A);
    wr_cmd(8'h0B);
    wr_cmd(8'h0C);
    check("t5_ovf_before", overflow, 1);
    stop = 1'b1;
    wr   = 1'b1;
    cmd  = 8'h0D;
    @(negedge clk_50M);
    stop = 1'b0;
    wr   = 1'b0;
    check("t5_snd_off", snd_off, 1);
    check("t5_busy", busy, 0);
    check("t5_overflow", overflow, 0);
    check("t5_full", fifo_full, 0);
    check("t5_tone_sel", tone_sel, 0);
    repeat (20) @(negedge clk_50M);
    check("t5_busy_later", busy, 0);
    check("t5_off_later", snd_off, 1);

    // Asynchronous reset in the middle of a note
    wr_cmd(8'h13);
    wait_play(lat);
    wr_cmd(8'h0A);
    wr_cmd(8'h0B);
    check("t6_playing", snd_off, 0);
    #2;
    reset = 1'b1;
    #1;
    check("t6_snd_off", snd_off, 1);
    check("t6_busy", busy, 0);
    check("t6_tone_sel", tone_sel, 0);
    check("t6_full", fifo_full, 0);
    check("t6_overflow", overflow, 0);
    @(negedge clk_50M);
    reset = 1'b0;
    @(negedge clk_50M);
    check("t6_busy_after", busy, 0);
    wr_cmd(8'h0C);
    wait_play(lat);
    check("t6_latency", lat, 2);
    play_len(3'd4, n, bad);
    check("t6_play_len", n, 10);
    check("t6_tone_bad", bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
